// File: rtl/sram_ctrl.sv
// sram_ctrl: byte-addressed, little-endian on-chip SRAM with req/ready handshake and wait states.
// Define SRAM_BITBAND_EN to enable the bit-band alias region (word-only, read-modify-write).
module sram_ctrl #(
    parameter logic [31:0] BASE_ADDR     = 32'h2000_0000,
    parameter int unsigned SIZE_BYTES    = 98304,
    parameter int unsigned WAIT_STATES   = 0,
    parameter logic [31:0] BB_ALIAS_BASE = 32'h2200_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        write,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic        ready,
    output logic        error,
    output logic [31:0] data_out
);
    localparam int unsigned AW = $clog2(SIZE_BYTES);

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, BB_RMW, DONE} state_t;

    state_t        state_q;
    logic [3:0]    wait_cnt_q;
    logic          ready_q;
    logic          error_q;
    logic [31:0]   data_out_q;

    logic          write_q;
    logic [1:0]    size_q;
    logic [31:0]   data_q;
    logic [AW-1:0] idx_q;

    logic [7:0]    mem [SIZE_BYTES];

    logic [32:0]   main_off;
    logic [32:0]   main_end;
    logic [2:0]    nbytes;
    logic          misaligned;
    logic          main_hit;
    logic          reject;
    logic [31:0]   rd_data;

`ifdef SRAM_BITBAND_EN
    localparam logic [32:0] BB_SPAN = 33'(SIZE_BYTES) << 5;
    logic [32:0]   bb_off;
    logic          bb_hit;
    logic          bb_q;
    logic [2:0]    bit_q;
    logic [7:0]    bb_byte;
    logic [7:0]    rmw_q;
`else
    logic          unused_bb;
    assign unused_bb = ^BB_ALIAS_BASE;
`endif

    // Request decode; offsets carry a borrow bit so addresses below a base never alias in.
    always_comb begin
        case (size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        main_off   = {1'b0, address} - {1'b0, BASE_ADDR};
        main_end   = main_off + 33'(nbytes);
        main_hit   = !main_off[32] && (main_end <= 33'(SIZE_BYTES));
        misaligned = (size == 2'd1 && address[0]) || (size == 2'd2 && address[1:0] != 2'b00);
        reject     = (size == 2'd3) || misaligned || !main_hit;
`ifdef SRAM_BITBAND_EN
        bb_off = {1'b0, address} - {1'b0, BB_ALIAS_BASE};
        bb_hit = !bb_off[32] && (bb_off < BB_SPAN);
        if (bb_hit) begin
            reject = (size != 2'd2) || (address[1:0] != 2'b00);
        end
`endif
    end

    always_comb begin
        rd_data = '0;
        case (size_q)
            2'd0:    rd_data[7:0]  = mem[idx_q];
            2'd1:    rd_data[15:0] = {mem[idx_q + AW'(1)], mem[idx_q]};
            default: rd_data = {mem[idx_q + AW'(3)], mem[idx_q + AW'(2)],
                                mem[idx_q + AW'(1)], mem[idx_q]};
        endcase
`ifdef SRAM_BITBAND_EN
        if (bb_q) begin
            rd_data = {31'b0, mem[idx_q][bit_q]};
        end
`endif
    end

`ifdef SRAM_BITBAND_EN
    always_comb begin
        bb_byte        = mem[idx_q];
        bb_byte[bit_q] = data_q[0];
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            data_out_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (reject) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            error_q <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state_q    <= WAIT;
                            wait_cnt_q <= 4'(WAIT_STATES - 1);
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= ACCESS;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ACCESS: begin
`ifdef SRAM_BITBAND_EN
                    if (bb_q && write_q) begin
                        state_q <= BB_RMW;
                    end else
`endif
                    begin
                        state_q    <= DONE;
                        ready_q    <= 1'b1;
                        data_out_q <= write_q ? 32'd0 : rd_data;
                    end
                end
`ifdef SRAM_BITBAND_EN
                BB_RMW: begin
                    state_q <= DONE;
                    ready_q <= 1'b1;
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request capture and array update; an async reset forces IDLE so no pending write commits.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && req) begin
            write_q <= write;
            size_q  <= size;
            data_q  <= data_in;
            idx_q   <= main_off[AW-1:0];
`ifdef SRAM_BITBAND_EN
            bb_q    <= bb_hit;
            bit_q   <= bb_off[4:2];
            if (bb_hit) begin
                idx_q <= bb_off[AW+4:5];
            end
`endif
        end
`ifdef SRAM_BITBAND_EN
        if (state_q == ACCESS) begin
            rmw_q <= bb_byte;
        end
        if (state_q == BB_RMW) begin
            mem[idx_q] <= rmw_q;
        end
        if (state_q == ACCESS && write_q && !bb_q) begin
`else
        if (state_q == ACCESS && write_q) begin
`endif
            mem[idx_q] <= data_q[7:0];
            if (size_q != 2'd0) begin
                mem[idx_q + AW'(1)] <= data_q[15:8];
            end
            if (size_q == 2'd2) begin
                mem[idx_q + AW'(2)] <= data_q[23:16];
                mem[idx_q + AW'(3)] <= data_q[31:24];
            end
        end
    end

    assign ready    = ready_q;
    assign error    = error_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (0 and 3 wait states) driven with directed and random
// transfers, checked against a byte-array reference model of the memory map.
`timescale 1ns/1ps
module tb_sram_ctrl;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] BB   = 32'h2200_0000;
    localparam int          SIZE = 98304;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req [2];
    logic        wr [2];
    logic [1:0]  sz [2];
    logic [31:0] addr [2];
    logic [31:0] din [2];
    logic        rdy [2];
    logic        err [2];
    logic [31:0] dout [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [2][SIZE];

    always #5 clock = ~clock;

    sram_ctrl #(.WAIT_STATES(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .req(req[0]), .write(wr[0]), .size(sz[0]),
        .address(addr[0]), .data_in(din[0]), .ready(rdy[0]), .error(err[0]), .data_out(dout[0])
    );
    sram_ctrl #(.WAIT_STATES(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .req(req[1]), .write(wr[1]), .size(sz[1]),
        .address(addr[1]), .data_in(din[1]), .ready(rdy[1]), .error(err[1]), .data_out(dout[1])
    );

    function automatic int ws(int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: memory map rules applied to a plain byte array.
    function automatic void model(int i, bit w, logic [1:0] s, logic [31:0] a, logic [31:0] d,
                                  output bit e, output logic [31:0] rd, output int lat);
        longint off = longint'(a) - longint'(BASE);
        longint bo  = longint'(a) - longint'(BB);
        int n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        int bidx;
        int bitn;
        rd = 32'd0;
        e = 1'b0;
        lat = ws(i) + 2;
        bidx = int'(bo / 32);
        bitn = int'((bo / 4) % 8);
`ifdef SRAM_BITBAND_EN
        if (bo >= 0 && bo < longint'(SIZE) * 32) begin
            if (s != 2'd2 || a[1:0] != 2'b00) begin
                e = 1'b1;
                lat = 1;
            end else if (w) begin
                mm[i][bidx][bitn] = d[0];
                lat = ws(i) + 3;
            end else begin
                rd = {31'b0, mm[i][bidx][bitn]};
            end
            return;
        end
`endif
        if (s == 2'd3 || (a & 32'(n - 1)) != 0 || off < 0 || off + n > SIZE) begin
            e = 1'b1;
            lat = 1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (w) mm[i][int'(off) + k] = d[8*k +: 8];
            else   rd[8*k +: 8] = mm[i][int'(off) + k];
        end
    endfunction

    task automatic xfer(int i, bit w, logic [1:0] s, logic [31:0] a, logic [31:0] d, string nm,
                        output logic [31:0] rd, output bit e, output int lat);
        bit          ee;
        logic [31:0] er;
        int          el;
        model(i, w, s, a, d, ee, er, el);
        @(negedge clock);
        req[i] = 1'b1; wr[i] = w; sz[i] = s; addr[i] = a; din[i] = d;
        @(posedge clock); #1;
        req[i] = 1'b0; wr[i] = 1'($urandom); sz[i] = 2'($urandom);
        addr[i] = $urandom; din[i] = $urandom;
        lat = 1;
        while (rdy[i] !== 1'b1 && lat < 30) begin
            @(posedge clock); #1;
            lat++;
        end
        rd = dout[i];
        e = err[i];
        chk({nm, " latency"}, 32'(lat), 32'(el));
        chk({nm, " error"}, {31'b0, e}, {31'b0, ee});
        if (!w || ee) chk({nm, " data_out"}, rd, er);
        @(posedge clock); #1;
        chk({nm, " ready one cycle"}, {31'b0, rdy[i]}, 32'd0);
    endtask

    // Outside the ready strobe, data_out and error must read as zero.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (rdy[i] !== 1'b1) begin
                    checks++;
                    if (dout[i] !== 32'd0 || err[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL idle outputs dut%0d: data_out=%h error=%b, expected 0 and 0",
                                 i, dout[i], err[i]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        bit          e;
        int          l;
        logic [31:0] a;
        logic [1:0]  s;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'd0; addr[i] = 32'd0; din[i] = 32'd0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset ready", {31'b0, rdy[i]}, 32'd0);
            chk("reset error", {31'b0, err[i]}, 32'd0);
            chk("reset data_out", dout[i], 32'd0);
        end
        @(negedge clock) reset_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            for (int o = 0; o < 64; o += 4) begin
                xfer(i, 1'b1, 2'd2, BASE + 32'(o), $urandom, "init low", rd, e, l);
                xfer(i, 1'b1, 2'd2, BASE + 32'(SIZE - 64 + o), $urandom, "init high", rd, e, l);
            end
        end

        xfer(0, 1'b1, 2'd2, 32'h2000_0010, 32'hDEAD_BEEF, "wr word", rd, e, l);
        xfer(0, 1'b0, 2'd2, 32'h2000_0010, 32'd0, "rd word", rd, e, l);
        chk("lit word read", rd, 32'hDEAD_BEEF);
        chk("lit word latency", 32'(l), 32'd2);
        xfer(0, 1'b1, 2'd0, 32'h2000_0013, 32'hFFFF_FF5A, "wr byte", rd, e, l);
        xfer(0, 1'b0, 2'd2, 32'h2000_0010, 32'd0, "rd after byte", rd, e, l);
        chk("lit byte merge", rd, 32'h5AAD_BEEF);
        xfer(0, 1'b0, 2'd1, 32'h2000_0012, 32'd0, "rd half", rd, e, l);
        chk("lit half read", rd, 32'h0000_5AAD);

        xfer(0, 1'b0, 2'd2, 32'h2000_0011, 32'd0, "misaligned", rd, e, l);
        chk("lit misaligned error", {31'b0, e}, 32'd1);
        chk("lit misaligned latency", 32'(l), 32'd1);
        xfer(0, 1'b1, 2'd2, 32'h2001_7FFE, 32'h1111_1111, "cross end", rd, e, l);
        chk("lit cross end error", {31'b0, e}, 32'd1);
        xfer(0, 1'b1, 2'd3, 32'h2000_0010, 32'h2222_2222, "size3", rd, e, l);
        chk("lit size3 error", {31'b0, e}, 32'd1);
        xfer(0, 1'b0, 2'd2, 32'h1FFF_FFFC, 32'd0, "below base", rd, e, l);
        chk("lit below base error", {31'b0, e}, 32'd1);
        chk("lit below base data", rd, 32'd0);
        xfer(0, 1'b0, 2'd2, 32'h2000_0010, 32'd0, "rd after errors", rd, e, l);
        chk("lit unchanged", rd, 32'h5AAD_BEEF);

`ifdef SRAM_BITBAND_EN
        xfer(0, 1'b1, 2'd2, 32'h2200_0208, 32'd0, "bb clear", rd, e, l);
        chk("lit bb write latency", 32'(l), 32'd3);
        xfer(0, 1'b0, 2'd0, 32'h2000_0010, 32'd0, "bb byte view", rd, e, l);
        chk("lit bb cleared byte", rd, 32'h0000_00EB);
        xfer(0, 1'b0, 2'd2, 32'h2200_0208, 32'd0, "bb read0", rd, e, l);
        chk("lit bb read0", rd, 32'd0);
        xfer(0, 1'b1, 2'd2, 32'h2200_0208, 32'd1, "bb set", rd, e, l);
        xfer(0, 1'b0, 2'd2, 32'h2200_0208, 32'd0, "bb read1", rd, e, l);
        chk("lit bb read1", rd, 32'd1);
        xfer(0, 1'b0, 2'd1, 32'h2200_0208, 32'd0, "bb half", rd, e, l);
        chk("lit bb half error", {31'b0, e}, 32'd1);
`else
        xfer(0, 1'b0, 2'd2, 32'h2200_0208, 32'd0, "alias off", rd, e, l);
        chk("lit alias error", {31'b0, e}, 32'd1);
`endif

        xfer(1, 1'b1, 2'd2, 32'h2000_0020, 32'hCAFE_F00D, "ws3 write", rd, e, l);
        xfer(1, 1'b0, 2'd2, 32'h2000_0020, 32'd0, "ws3 read", rd, e, l);
        chk("lit ws3 latency", 32'(l), 32'd5);
        chk("lit ws3 data", rd, 32'hCAFE_F00D);

        // Abandon a write while it is still waiting.
        @(negedge clock);
        req[1] = 1'b1; wr[1] = 1'b1; sz[1] = 2'd2; addr[1] = 32'h2000_0020; din[1] = 32'h1234_5678;
        @(posedge clock); #1;
        req[1] = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("reset in wait ready", {31'b0, rdy[1]}, 32'd0);
        chk("reset in wait data_out", dout[1], 32'd0);
        @(negedge clock) reset_n = 1'b1;
        xfer(1, 1'b0, 2'd2, 32'h2000_0020, 32'd0, "after abandoned write", rd, e, l);
        chk("lit old data kept", rd, 32'hCAFE_F00D);

        // Reset while ready is high drops the strobe at once.
        @(negedge clock);
        req[0] = 1'b1; wr[0] = 1'b0; sz[0] = 2'd2; addr[0] = 32'h2000_0010;
        @(posedge clock); #1;
        req[0] = 1'b0;
        @(posedge clock); #1;
        chk("pre-reset ready", {31'b0, rdy[0]}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async reset ready", {31'b0, rdy[0]}, 32'd0);
        chk("async reset data_out", dout[0], 32'd0);
        @(negedge clock) reset_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                5:       a = BASE + 32'(SIZE - 8) + 32'($urandom_range(0, 7));
                6:       a = BASE - 32'd4 + 32'($urandom_range(0, 3));
                7:       a = BB + 32'($urandom_range(0, 2047));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            xfer(n % 2, 1'($urandom), s, a, $urandom, "random", rd, e, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
